// File: rtl/bit_packer_if.sv
// Handshake bundle for bit_packer: field beats in, packed words out, plus fill level.
// The slave modport is the packer's view; master is the producer/consumer side.
interface bit_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic [6:0]  fill_level;

  modport slave (
    input  in_valid, in_data, in_len, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_bits, fill_level
  );

  modport master (
    output in_valid, in_data, in_len, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_bits, fill_level
  );
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length fields (0..32 bits) into 32-bit words through a 64-bit accumulator.
// Define BIT_PACKER_MSB_FIRST_EN for MSB-first packing; default build packs LSB-first.
module bit_packer (
  input  logic          clk,
  input  logic          rst_n,
  bit_packer_if.slave   bus
);
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_bits_q, out_bits_d;

  logic [5:0]  len_eff_s;
  logic [63:0] field_s;
  logic [63:0] acc_emit_s;
  logic [6:0]  cnt_emit_s;
  logic        accept_s;
  logic        emit_s;
`ifdef BIT_PACKER_MSB_FIRST_EN
  logic [6:0]  shamt_s;
`endif

  assign len_eff_s = (bus.in_len > 6'd32) ? 6'd32 : bus.in_len;
  assign field_s   = {32'd0, bus.in_data} & ~(64'hFFFF_FFFF_FFFF_FFFF << len_eff_s);

  // Combinational ready so a draining consumer lets a new field in the same cycle.
  assign bus.in_ready = rst_n && (state_q == ST_FILL) && ((cnt_q < 7'd32) || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign emit_s       = out_valid_q && bus.out_ready;

  // Next accumulator, count and state: retire the emitted word first, then append the field.
  always_comb begin
    acc_emit_s = acc_q;
    cnt_emit_s = cnt_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
`ifdef BIT_PACKER_MSB_FIRST_EN
    shamt_s    = 7'd0;
`endif

    if (emit_s) begin
`ifdef BIT_PACKER_MSB_FIRST_EN
      acc_emit_s = acc_q << 32;
`else
      acc_emit_s = acc_q >> 32;
`endif
      cnt_emit_s = (cnt_q > 7'd32) ? (cnt_q - 7'd32) : 7'd0;
    end else begin
      acc_emit_s = acc_q;
      cnt_emit_s = cnt_q;
    end

    if (accept_s) begin
`ifdef BIT_PACKER_MSB_FIRST_EN
      // Field lands just below the bits already held, which sit left-aligned at bit 63.
      shamt_s = 7'd64 - cnt_emit_s - {1'b0, len_eff_s};
      acc_d   = acc_emit_s | (field_s << shamt_s);
`else
      acc_d   = acc_emit_s | (field_s << cnt_emit_s);
`endif
      cnt_d   = cnt_emit_s + {1'b0, len_eff_s};
    end else begin
      acc_d   = acc_emit_s;
      cnt_d   = cnt_emit_s;
    end

    case (state_q)
      ST_FILL: begin
        if (accept_s && bus.in_flush && (cnt_d != 7'd0)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        if (emit_s && (cnt_q <= 7'd32)) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Output words are decoded from the next state so they appear the cycle after the completing beat.
  always_comb begin
    out_valid_d = (state_d == ST_FLUSH) || (cnt_d >= 7'd32);
    if (state_d == ST_FLUSH) begin
      if (cnt_d >= 7'd32) begin
        out_bits_d = 6'd32;
      end else begin
        out_bits_d = cnt_d[5:0];
      end
    end else begin
      out_bits_d = 6'd32;
    end
`ifdef BIT_PACKER_MSB_FIRST_EN
    out_data_d = acc_d[63:32];
`else
    out_data_d = acc_d[31:0];
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      acc_q       <= 64'd0;
      cnt_q       <= 7'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_bits_q  <= 6'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_bits   = out_bits_q;
  assign bus.fill_level = cnt_q;
endmodule

// File: tb/tb_bit_packer.sv
// Scoreboard bench for bit_packer: a bit-stream queue model predicts every emitted word.
module tb_bit_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   emit_cnt = 0;
  int   ready_mode = 0;

  bit_packer_if bus ();

  bit_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: stream of packed bits not yet cut into words, and words awaiting emission.
  bit          stream_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_bits_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cut_word(input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
`ifdef BIT_PACKER_MSB_FIRST_EN
      w[31-i] = stream_q.pop_front();
`else
      w[i] = stream_q.pop_front();
`endif
    end
    exp_data_q.push_back(w);
    exp_bits_q.push_back(n);
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: fill level vs model, emitted words vs queue, then fold in this cycle's accepted field.
  always @(negedge clk) begin
    if (!rst_n) begin
      stream_q.delete();
      exp_data_q.delete();
      exp_bits_q.delete();
    end else begin
      int held;
      held = stream_q.size();
      foreach (exp_bits_q[k]) held += exp_bits_q[k];
      chk("fill_level", 64'(bus.fill_level), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        emit_cnt++;
        if (exp_data_q.size() == 0) begin
          chk("unexpected_word", 64'(bus.out_data), 64'hDEAD_0000_0000);
        end else begin
          chk("word_data", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
          chk("word_bits", 64'(bus.out_bits), 64'(exp_bits_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        int len;
        len = (bus.in_len > 6'd32) ? 32 : int'(bus.in_len);
`ifdef BIT_PACKER_MSB_FIRST_EN
        for (int b = len - 1; b >= 0; b--) stream_q.push_back(bus.in_data[b]);
`else
        for (int b = 0; b < len; b++) stream_q.push_back(bus.in_data[b]);
`endif
        while (stream_q.size() >= 32) cut_word(32);
        if (bus.in_flush && stream_q.size() > 0) cut_word(stream_q.size());
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] l, input logic f);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    bus.in_flush = f;
    @(negedge clk);
    while (!bus.in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) chk("send_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int waited;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_len   = 6'd0;
    bus.in_flush = 1'b0;
    bus.out_ready = 1'b0;

    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_fill", 64'(bus.fill_level), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_bits", 64'(bus.out_bits), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ready_mode = 1;

`ifdef BIT_PACKER_MSB_FIRST_EN
    send(32'hA, 6'd4, 1'b0);
    send(32'h5, 6'd4, 1'b1);
    @(negedge clk);
    chk("msb_data", 64'(bus.out_data), 64'hA500_0000);
    chk("msb_bits", 64'(bus.out_bits), 64'd8);
    @(posedge clk);
    #1;
`else
    send(32'h11, 6'd8, 1'b0);
    send(32'h22, 6'd8, 1'b0);
    send(32'h33, 6'd8, 1'b0);
    send(32'h44, 6'd8, 1'b0);
    @(negedge clk);
    chk("bytes_valid", 64'(bus.out_valid), 64'd1);
    chk("bytes_data", 64'(bus.out_data), 64'h4433_2211);
    chk("bytes_bits", 64'(bus.out_bits), 64'd32);
    @(posedge clk);
    #1;

    send(32'hFFFF_FABC, 6'd12, 1'b0);
    send(32'h0012_3456, 6'd24, 1'b0);
    @(negedge clk);
    chk("spill_data", 64'(bus.out_data), 64'h2345_6ABC);
    @(negedge clk);
    chk("spill_fill", 64'(bus.fill_level), 64'd4);
    @(posedge clk);
    #1;
    send(32'd0, 6'd0, 1'b1);
    @(negedge clk);
    chk("flush_valid", 64'(bus.out_valid), 64'd1);
    chk("flush_data", 64'(bus.out_data), 64'h1);
    chk("flush_bits", 64'(bus.out_bits), 64'd4);
    @(negedge clk);
    chk("flush_fill", 64'(bus.fill_level), 64'd0);
    @(posedge clk);
    #1;

    ready_mode = 0;
    send(32'h000A_BCDE, 6'd20, 1'b0);
    send(32'h0001_2345, 6'd20, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_data", 64'(bus.out_data), 64'h345A_BCDE);
    end
    @(posedge clk);
    #1 ready_mode = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_fill_after", 64'(bus.fill_level), 64'd8);
    @(posedge clk);
    #1;
    send(32'd0, 6'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
`endif

    e0 = emit_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_len   = 6'd32;
      @(negedge clk);
      chk("thr_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("thr_words", 64'(emit_cnt - e0), 64'd8);
    @(posedge clk);
    #1;

    ready_mode = 0;
    send($urandom, 6'd20, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_fill", 64'(bus.fill_level), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    ready_mode = 1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);
    e0 = emit_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_no_word", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 7) == 0));
    end
    ready_mode = 1;
    send(32'd0, 6'd0, 1'b1);
    waited = 0;
    while ((bus.fill_level != 7'd0 || bus.out_valid) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    chk("drain_timeout", 64'(waited < 200), 64'd1);
    chk("drain_pending", 64'(exp_data_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameters: none; word width fixed at 32, accumulator fixed at 64.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  field beat offered; consumes fields produced by the shift/extract stage.
REQ-005 in_ready  output  1  field beat accepted when in_valid && in_ready.
REQ-006 in_data  input  32  field value, right-aligned.
REQ-007 in_len  input  6  field length in bits; 0 = no bits; 33..63 treated as 32.
REQ-008 in_flush  input  1  with accepted beat: emit the partial word after appending this field.
REQ-009 out_valid  output  1  packed word available.
REQ-010 out_ready  input  1  word consumed when out_valid && out_ready.
REQ-011 out_data  output  32  packed word, padding bits zero.
REQ-012 out_bits  output  6  count of valid bits in out_data (1..32).
REQ-013 fill_level  output  7  bits currently held in accumulator (0..63).

Function
REQ-014 State: 64-bit acc, 7-bit cnt, FSM {FILL, FLUSH}.
REQ-015 in_data bits at and above effective in_len are masked to zero before append.
REQ-016 FILL: out_valid = (cnt >= 32), out_bits = 32, out_data = lowest 32 packed bits.
REQ-017 FILL: in_ready = (cnt < 32) || out_ready; combinational out_ready->in_ready path is required.
REQ-018 Emit (out handshake) and accept in same cycle: acc shifted right 32, cnt -= 32, then field ORed in at bit cnt-32; cnt never exceeds 63.
REQ-019 Accept without emit: field ORed in at bit cnt, cnt += len.
REQ-020 Latency: word completed by an accepted beat presents out_valid on the following cycle.
REQ-021 Accepted beat with in_flush=1: if resulting cnt = 0 stay FILL, else enter FLUSH.
REQ-022 FLUSH: in_ready = 0, out_valid = 1, out_bits = min(cnt, 32); on handshake with cnt > 32 emit 32 bits and stay; with cnt <= 32 emit remainder zero-padded, cnt = 0, return to FILL.
REQ-023 in_len = 0 beat: accepted normally, acc and cnt unchanged, in_flush honoured.
REQ-024 out_data and out_bits hold stable while out_valid && !out_ready.
REQ-025 fill_level = cnt.

Reset
REQ-026 rst_n low: acc = 0, cnt = 0, state = FILL, out_valid = 0, in_ready = 0, out_data = 0, out_bits = 0, fill_level = 0, all taking effect immediately.
REQ-027 Reset mid-FLUSH or mid-word discards all held bits; in_ready = 1 on the first cycle after release.

Configuration
REQ-028 Macro BIT_PACKER_MSB_FIRST_EN defined: fields are packed from bit 31 downward, first field most significant, partial words left-aligned, padding in low bits.
REQ-029 Macro BIT_PACKER_MSB_FIRST_EN undefined: fields are packed LSB-first from bit 0 upward, partial words right-aligned, padding in high bits.
REQ-030 Ports, handshake, latency and FSM are identical in both builds.

Verification
REQ-031 LSB-first, out_ready=1: len=8 beats 0x11,0x22,0x33,0x44 -> one word 0x44332211, out_bits=32, out_valid the cycle after 4th accept.
REQ-032 Masking and spill: len=12 data 0xFFFFFABC, then len=24 data 0x123456 -> word 0x23456ABC, fill_level=4; then len=0 flush=1 -> word 0x00000001, out_bits=4, fill_level returns to 0.
REQ-033 Backpressure: out_ready=0 with fill_level=40 -> out_valid=1, in_ready=0, out_data stable for 5 cycles; out_ready=1 -> word emitted, fill_level=8.
REQ-034 Throughput: 8 consecutive len=32 beats with out_ready=1 -> in_ready never drops, one word per cycle, words equal inputs in order.
REQ-035 Reset during FLUSH (fill_level=20) -> out_valid=0 and fill_level=0 immediately, no partial word after release.
REQ-036 With BIT_PACKER_MSB_FIRST_EN: len=4 0xA, len=4 0x5 flush=1 -> out_data 0xA5000000, out_bits=8.
